sigchunk: RTL and testbench
===========================

// Module: sigchunk
// PURPOSE
//  Consumer end of the correlator signal delay line: takes the delayed, valid-gated radio stream and
//  frames it into LOOP0-sample chunks, flagging first/last of each. Buffers samples in a small FIFO and
//  presents them on a valid/ready interface to the correlator-chain sequencer. Correlator clock domain.
// PARAMETERS
//  RADIOS      32  number of (1-bit, IQ) signal sources
//  LOOP0       3   chunk length in samples (inner-loop count); must be >= 1
//  FIFO_DEPTH  4   sample buffer entries; power of two, >= 2
// PORTS
//  clock       in   1             correlator clock; all logic on rising edge
//  reset       in   1             synchronous, active-high reset
//  valid_i     in   1             input sample strobe (no backpressure upstream)
//  sig_ii      in   RADIOS        delayed in-phase bits
//  sig_qi      in   RADIOS        delayed quadrature bits
//  valid_o     out  1             head sample available
//  ready_i     in   1             consumer accepts head sample
//  first_o     out  1             head sample is chunk index 0
//  last_o      out  1             head sample is chunk index LOOP0-1
//  sig_io      out  RADIOS        head in-phase bits
//  sig_qo      out  RADIOS        head quadrature bits
//  level_o     out  clog2(FD)+1   current FIFO occupancy
//  overflow_o  out  1             sticky: a sample was dropped
// BEHAVIOUR
//  - Reset (synchronous, active-high): FIFO emptied, chunk counter=0, overflow_o=0; all outputs 0.
//  - Chunk counter cnt (0..LOOP0-1) advances on EVERY valid_i, stored or dropped; wraps LOOP0-1 -> 0.
//    Framing therefore stays locked to the source. Stored entry = {cnt==LOOP0-1, cnt==0, sig_qi, sig_ii}.
//    LOOP0==1: every sample has first=last=1.
//  - Push when valid_i && (!full || pop). Pop when valid_o && ready_i. Simultaneous push+pop at full:
//    both occur, level unchanged, no drop. Push+pop at empty: sample written, level becomes 1.
//  - Latency: valid_i at edge t -> valid_o=1 after edge t (usable cycle t+1); no same-cycle bypass.
//  - valid_o = (level != 0). Head data stable while valid_o && !ready_i. first_o/last_o/sig_io/sig_qo
//    forced to 0 whenever valid_o=0.
//  - Overflow: valid_i while full and no pop -> sample dropped, cnt still advances, overflow_o set
//    and held until reset. No other recovery; downstream treats overflow as fatal.
//  - Pointers wrap modulo FIFO_DEPTH; level_o counts 0..FIFO_DEPTH inclusive.
//  - ready_i with empty FIFO: no effect. Reset mid-chunk: partial chunk discarded; next valid_i first.
// STRUCTURE
//  - Shared package/header: chunk-flag bit positions {LAST, FIRST} within the entry word, entry width
//    2*RADIOS+2 helper; reused by the correlator sequencer.
//  - One sub-module: sigfifo (synchronous register-array FIFO, first-word-fall-through, level output,
//    full/empty flags). sigchunk holds the chunk counter, flag generation, overflow, output gating.
// TESTING
//  1. Reset then 6 back-to-back valid_i, ready_i=1, LOOP0=3 -> 6 outputs, first on #0,#3, last on #2,#5,
//     each valid_o one cycle after its valid_i; data matches.
//  2. ready_i=0, 5 valid_i, FIFO_DEPTH=4 -> level_o=4, 5th dropped, overflow_o=1 and stays 1; next chunk
//     starts on the 7th input (first_o on it).
//  3. FIFO full, valid_i && ready_i same cycle -> no drop, level_o stays 4, overflow_o stays 0.
//  4. Gapped valid_i (every 3rd cycle) with random ready_i -> order preserved, flags follow input count,
//     outputs 0 whenever valid_o=0.
//  5. Reset asserted after 2 samples of a chunk -> valid_o=0, level_o=0 next cycle; next sample first_o=1.
//  6. LOOP0=1 -> every output has first_o=last_o=1.

Source files
------------

// File: rtl/sigchunk_pkg.sv
// sigchunk_pkg: entry word layout shared by the chunker and the correlator sequencer
package sigchunk_pkg;

    localparam int FLAG_FIRST = 0;
    localparam int FLAG_LAST  = 1;

    function automatic int entry_w(input int radios);
        return 2 * radios + 2;
    endfunction

    function automatic int flag_pos(input int radios, input int flag);
        return 2 * radios + flag;
    endfunction

endpackage

// File: rtl/sigfifo.sv
// sigfifo: register-array first-word-fall-through FIFO with occupancy level
module sigfifo #(
    parameter int W     = 66,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // pointers wrap naturally since DEPTH is a power of two; caller never pops empty or pushes full without popping
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // storage array needs no reset; contents are only seen when level is non-zero
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/sigchunk.sv
// sigchunk: frames the delayed radio stream into LOOP0-sample chunks and buffers it for the sequencer
module sigchunk
    import sigchunk_pkg::*;
#(
    parameter int RADIOS     = 32,
    parameter int LOOP0      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        valid_i,
    input  logic [RADIOS-1:0]           sig_ii,
    input  logic [RADIOS-1:0]           sig_qi,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        first_o,
    output logic                        last_o,
    output logic [RADIOS-1:0]           sig_io,
    output logic [RADIOS-1:0]           sig_qo,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        overflow_o
);

    localparam int W  = entry_w(RADIOS);
    localparam int FP = flag_pos(RADIOS, FLAG_FIRST);
    localparam int LP = flag_pos(RADIOS, FLAG_LAST);
    localparam int CW = (LOOP0 > 1) ? $clog2(LOOP0) : 1;
    localparam logic [CW-1:0] CMAX = CW'(LOOP0 - 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign push    = valid_i && (!full || pop);

    // chunk position advances on every input sample, stored or dropped, so framing tracks the source
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (valid_i) cnt <= (cnt == CMAX) ? '0 : cnt + 1'b1;
            if (valid_i && full && !pop) overflow_o <= 1'b1;
        end
    end

    sigfifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({cnt == CMAX, cnt == '0, sig_qi, sig_ii}),
        .dout  (head),
        .level (level_o),
        .full  (full),
        .empty (empty)
    );

    // head fields are forced low whenever nothing is available
    always_comb begin
        first_o = valid_o ? head[FP] : 1'b0;
        last_o  = valid_o ? head[LP] : 1'b0;
        sig_io  = valid_o ? head[RADIOS-1:0] : '0;
        sig_qo  = valid_o ? head[2*RADIOS-1:RADIOS] : '0;
    end

endmodule

// File: tb/tb_sigchunk.sv
// tb_sigchunk: directed checks of chunk framing, buffering, overflow and reset for sigchunk
module tb_sigchunk;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        ready_i;
    logic [31:0] sig_ii;
    logic [31:0] sig_qi;
    logic        valid_o, first_o, last_o, overflow_o;
    logic [31:0] sig_io, sig_qo;
    logic [2:0]  level_o;
    logic        u1_valid_o, u1_first_o, u1_last_o, u1_overflow_o;
    logic [31:0] u1_sig_io, u1_sig_qo;
    logic [2:0]  u1_level_o;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    sigchunk #(.RADIOS(32), .LOOP0(3), .FIFO_DEPTH(4)) u0 (
        .clock(clock), .reset(reset), .valid_i(valid_i), .sig_ii(sig_ii), .sig_qi(sig_qi),
        .valid_o(valid_o), .ready_i(ready_i), .first_o(first_o), .last_o(last_o),
        .sig_io(sig_io), .sig_qo(sig_qo), .level_o(level_o), .overflow_o(overflow_o)
    );

    sigchunk #(.RADIOS(32), .LOOP0(1), .FIFO_DEPTH(4)) u1 (
        .clock(clock), .reset(reset), .valid_i(valid_i), .sig_ii(sig_ii), .sig_qi(sig_qi),
        .valid_o(u1_valid_o), .ready_i(ready_i), .first_o(u1_first_o), .last_o(u1_last_o),
        .sig_io(u1_sig_io), .sig_qo(u1_sig_qo), .level_o(u1_level_o), .overflow_o(u1_overflow_o)
    );

    function automatic logic [31:0] si(input int k);
        return 32'hA5A5_0000 | 32'(k);
    endfunction

    function automatic logic [31:0] sq(input int k);
        return 32'h5A5A_0000 | (32'(k) << 8);
    endfunction

    function automatic logic [65:0] ent(input int k, input int n);
        return {(k % n) == n - 1, (k % n) == 0, sq(k), si(k)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input int k);
        valid_i = v;
        ready_i = r;
        sig_ii  = si(k);
        sig_qi  = sq(k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid_o, first_o, last_o, overflow_o, level_o, sig_io, sig_qo} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b f=%b l=%b ov=%b lvl=%0d i=%h q=%h expected all zero",
                     valid_o, first_o, last_o, overflow_o, level_o, sig_io, sig_qo);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, k);
            step();
            checks++;
            if ({valid_o, last_o, first_o, sig_qo, sig_io} !== {1'b1, ent(k, 3)} || level_o !== 3'd1) begin
                failures++;
                $display("FAIL stream_%0d got v=%b l=%b f=%b q=%h i=%h lvl=%0d expected %h lvl=1",
                         k, valid_o, last_o, first_o, sig_qo, sig_io, level_o, ent(k, 3));
            end
        end
        drive(1'b0, 1'b1, 0);
        step();
        checks++;
        if ({valid_o, first_o, last_o, sig_io, sig_qo} !== '0 || level_o !== 3'd0) begin
            failures++;
            $display("FAIL stream_drained got v=%b f=%b l=%b i=%h q=%h lvl=%0d expected zeros",
                     valid_o, first_o, last_o, sig_io, sig_qo, level_o);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_lvl [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic       exp_ov  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, k);
            step();
            checks++;
            if (level_o !== exp_lvl[k] || overflow_o !== exp_ov[k]) begin
                failures++;
                $display("FAIL overflow_fill_%0d got lvl=%0d ov=%b expected lvl=%0d ov=%b",
                         k, level_o, overflow_o, exp_lvl[k], exp_ov[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({last_o, first_o, sig_qo, sig_io} !== ent(k, 3)) begin
                failures++;
                $display("FAIL overflow_drain_%0d got l=%b f=%b q=%h i=%h expected %h",
                         k, last_o, first_o, sig_qo, sig_io, ent(k, 3));
            end
            drive(1'b0, 1'b1, 0);
            step();
        end
        drive(1'b1, 1'b0, 5);
        step();
        drive(1'b1, 1'b0, 6);
        step();
        drive(1'b0, 1'b0, 0);
        checks++;
        if ({last_o, first_o, sig_io} !== {2'b10, si(5)} || overflow_o !== 1'b1 || level_o !== 3'd2) begin
            failures++;
            $display("FAIL overflow_in6 got l=%b f=%b i=%h ov=%b lvl=%0d expected l=1 f=0 i=%h ov=1 lvl=2",
                     last_o, first_o, sig_io, overflow_o, level_o, si(5));
        end
        drive(1'b0, 1'b1, 0);
        step();
        checks++;
        if ({last_o, first_o, sig_io} !== {2'b01, si(6)} || overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow_in7 got l=%b f=%b i=%h ov=%b expected l=0 f=1 i=%h ov=1",
                     last_o, first_o, sig_io, overflow_o, si(6));
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, k);
            step();
        end
        drive(1'b1, 1'b1, 4);
        step();
        checks++;
        if (level_o !== 3'd4 || overflow_o !== 1'b0 || sig_io !== si(1)) begin
            failures++;
            $display("FAIL full_pushpop got lvl=%0d ov=%b i=%h expected lvl=4 ov=0 i=%h",
                     level_o, overflow_o, sig_io, si(1));
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if ({last_o, first_o, sig_qo, sig_io} !== ent(k, 3)) begin
                failures++;
                $display("FAIL full_drain_%0d got l=%b f=%b q=%h i=%h expected %h",
                         k, last_o, first_o, sig_qo, sig_io, ent(k, 3));
            end
            drive(1'b0, 1'b1, 0);
            step();
        end
        checks++;
        if (valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL full_empty got v=%b ov=%b expected v=0 ov=0", valid_o, overflow_o);
        end
    endtask

    task automatic test_gapped();
        logic [65:0] q[$];
        int          n = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            logic        v;
            logic        r;
            logic        pop;
            logic [65:0] exp_head;
            v = (c % 3 == 0) && (n < 9);
            r = 1'($urandom_range(0, 1));
            drive(v, r, n);
            pop = (q.size() != 0) && r;
            step();
            if (pop) void'(q.pop_front());
            if (v) begin
                q.push_back(ent(n, 3));
                n++;
            end
            exp_head = (q.size() != 0) ? q[0] : '0;
            checks++;
            if (valid_o !== (q.size() != 0) || {last_o, first_o, sig_qo, sig_io} !== exp_head ||
                level_o !== 3'(q.size())) begin
                failures++;
                $display("FAIL gapped_c%0d got v=%b head=%h lvl=%0d expected v=%b head=%h lvl=%0d",
                         c, valid_o, {last_o, first_o, sig_qo, sig_io}, level_o,
                         q.size() != 0, exp_head, q.size());
            end
        end
    endtask

    task automatic test_midchunk_reset();
        do_reset();
        drive(1'b1, 1'b0, 0);
        step();
        drive(1'b1, 1'b0, 1);
        step();
        reset = 1'b1;
        drive(1'b0, 1'b0, 0);
        step();
        reset = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || level_o !== 3'd0) begin
            failures++;
            $display("FAIL midreset_clear got v=%b lvl=%0d expected v=0 lvl=0", valid_o, level_o);
        end
        drive(1'b1, 1'b0, 7);
        step();
        drive(1'b0, 1'b0, 0);
        checks++;
        if ({valid_o, last_o, first_o, sig_io} !== {3'b101, si(7)}) begin
            failures++;
            $display("FAIL midreset_first got v=%b l=%b f=%b i=%h expected v=1 l=0 f=1 i=%h",
                     valid_o, last_o, first_o, sig_io, si(7));
        end
    endtask

    task automatic test_loop1();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, k + 20);
            step();
            checks++;
            if ({u1_valid_o, u1_first_o, u1_last_o, u1_sig_io} !== {3'b111, si(k + 20)}) begin
                failures++;
                $display("FAIL loop1_%0d got v=%b f=%b l=%b i=%h expected v=1 f=1 l=1 i=%h",
                         k, u1_valid_o, u1_first_o, u1_last_o, u1_sig_io, si(k + 20));
            end
        end
        drive(1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_pushpop();
        test_gapped();
        test_midchunk_reset();
        test_loop1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
